pos_cache_read_ctrl: RTL and testbench

POS_CACHE_READ_CTRL -- requirements
Module: pos_cache_read_ctrl

---
 rtl/pos_cache_read_ctrl_pkg.sv | 25 ++
 rtl/pos_read_fifo.sv | 72 +++++++
 rtl/pos_cache_read_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pos_cache_read_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_cache_read_ctrl_pkg.sv
// Shared constants, FSM state type and small helpers for the position-cache
// read controller and its output buffer.
package pos_cache_read_ctrl_pkg;

    // One position is three fixed-point offsets packed side by side
    localparam int unsigned OFFSET_WIDTH       = 29;
    localparam int unsigned DATA_WIDTH         = 3 * OFFSET_WIDTH;
    localparam int unsigned NUM_NEIGHBOR_CELLS = 13;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Pointer width for a buffer of 'depth' entries, never below one bit
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = 32'($clog2(depth));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pos_read_fifo.sv
// Synchronous FIFO buffering cache read beats between the issue pipeline and
// the downstream consumer. Storage is cleared on reset so the head word reads
// as zero until the first write.
module pos_read_fifo
    import pos_cache_read_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] occ_next_c;

    // Wrap a pointer at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_c  = wr_en && (occupancy != CNT_W'(DEPTH));
    assign pop_c   = rd_en && valid;
    assign rd_data = mem[rd_ptr];

    // Occupancy bookkeeping; a simultaneous push and pop leaves it unchanged
    always_comb begin
        occ_next_c = occupancy;
        case ({push_c, pop_c})
            2'b10:   occ_next_c = occupancy + CNT_W'(1);
            2'b01:   occ_next_c = occupancy - CNT_W'(1);
            default: occ_next_c = occupancy;
        endcase
    end

    // Storage, pointers and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            valid     <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occupancy <= occ_next_c;
            valid     <= (occ_next_c != '0);
        end
    end

endmodule

// File: rtl/pos_cache_read_ctrl.sv
// Position-cache read controller: sweeps particle ids 0..particle_count-1
// across the home and neighbour position caches, captures the read data one
// cycle after each address and streams it out through a small FIFO under
// valid/ready flow control. Reads are only issued while the FIFO has room for
// them, so backpressure can never overflow the buffer.
// Optional feature: define POS_READ_PERF_EN to build the stall_cycles counter;
// otherwise stall_cycles is tied to zero.
module pos_cache_read_ctrl #(
    parameter int unsigned DATA_WIDTH         = pos_cache_read_ctrl_pkg::DATA_WIDTH,
    parameter int unsigned NUM_NEIGHBOR_CELLS = pos_cache_read_ctrl_pkg::NUM_NEIGHBOR_CELLS,
    parameter int unsigned ADDR_WIDTH         = 7,
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic [ADDR_WIDTH:0]                            particle_count,
    output logic [ADDR_WIDTH-1:0]                          particle_id,
    input  logic [(NUM_NEIGHBOR_CELLS+1)*DATA_WIDTH-1:0]   pos_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [(NUM_NEIGHBOR_CELLS+1)*DATA_WIDTH-1:0]   out_pos_data,
    output logic [ADDR_WIDTH-1:0]                          out_id,
    output logic                                           out_last,
    output logic                                           busy,
    output logic                                           done,
    output logic [31:0]                                    stall_cycles
);

    import pos_cache_read_ctrl_pkg::*;

    localparam int unsigned W      = (NUM_NEIGHBOR_CELLS + 1) * DATA_WIDTH;
    localparam int unsigned FW     = W + ADDR_WIDTH + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ROOM_W = CNT_W + 1;
    localparam int unsigned IDX_W  = ADDR_WIDTH + 1;

    state_e              state;
    state_e              state_next;
    logic [IDX_W-1:0]    count_q;
    logic [IDX_W-1:0]    issue_cnt;
    logic                in_flight;
    logic                last_in_flight;
    logic [CNT_W-1:0]    occupancy;
    logic [FW-1:0]       fifo_wr_data;
    logic [FW-1:0]       fifo_rd_data;

    logic [ROOM_W-1:0]   pending_c;
    logic                room_c;
    logic                launch_c;
    logic                issue_c;
    logic [IDX_W-1:0]    issue_addr_c;
    logic [IDX_W-1:0]    last_addr_c;
    logic                last_issue_c;
    logic                accept_c;
    logic                start_ok_c;

    // Room check counts both buffered beats and the read still in flight
    assign pending_c = ROOM_W'(occupancy) + ROOM_W'(in_flight);
    assign room_c    = (pending_c < ROOM_W'(FIFO_DEPTH));

    // The launching start issues id 0 directly so the first beat appears two
    // cycles after start; the buffer is always empty in IDLE.
    assign start_ok_c   = (state == IDLE) && start;
    assign launch_c     = start_ok_c && (particle_count != '0);
    assign issue_c      = launch_c || ((state == ISSUE) && room_c);
    assign issue_addr_c = launch_c ? '0 : issue_cnt;
    assign last_addr_c  = (launch_c ? particle_count : count_q) - IDX_W'(1);
    assign last_issue_c = issue_c && (issue_addr_c == last_addr_c);
    assign accept_c     = out_valid && out_ready;

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (particle_count == '0) begin
                        state_next = FINISH;
                    end else if (last_issue_c) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (last_issue_c) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (accept_c && out_last) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register with registered busy/done status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == FINISH);
        end
    end

    // Read issue: address register, counter and one-cycle in-flight tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            issue_cnt      <= '0;
            particle_id    <= '0;
            in_flight      <= 1'b0;
            last_in_flight <= 1'b0;
        end else begin
            in_flight      <= issue_c;
            last_in_flight <= last_issue_c;
            if (launch_c) begin
                count_q <= particle_count;
            end
            if (issue_c) begin
                particle_id <= issue_addr_c[ADDR_WIDTH-1:0];
                issue_cnt   <= issue_addr_c + IDX_W'(1);
            end
        end
    end

    // particle_id still holds the in-flight address when its data arrives
    assign fifo_wr_data = {last_in_flight, particle_id, pos_data};
    assign {out_last, out_id, out_pos_data} = fifo_rd_data;

    pos_read_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (in_flight),
        .wr_data   (fifo_wr_data),
        .rd_en     (out_ready),
        .rd_data   (fifo_rd_data),
        .valid     (out_valid),
        .occupancy (occupancy)
    );

`ifdef POS_READ_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles a beat waited on the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_ok_c) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pos_cache_read_ctrl.sv
// Scoreboard bench for pos_cache_read_ctrl: each sweep pushes its expected
// beats into a queue; a negedge monitor pops and compares accepted beats and
// checks that stalled beats hold steady.
module tb_pos_cache_read_ctrl;

    localparam int unsigned DW    = 87;
    localparam int unsigned NCELL = 14;
    localparam int unsigned W     = NCELL * DW;
    localparam int unsigned AW    = 7;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   particle_count;
    logic [AW-1:0] particle_id;
    logic [W-1:0]  pos_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pos_data;
    logic [AW-1:0] out_id;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [31:0]   stall_cycles;

    typedef struct {
        logic [AW-1:0] id;
        logic          last;
        logic [W-1:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   stall_seen = 0;
    int   stall_base = 0;

    always #5 clk = ~clk;

    // Cache model: every cell returns a distinct word derived from the address
    function automatic logic [W-1:0] make_data(input logic [AW-1:0] id);
        logic [W-1:0] d;
        d = '0;
        for (int c = 0; c < int'(NCELL); c++) begin
            d[c*DW +: DW] = DW'({4'(c), id, 8'hA5, ~id, id});
        end
        return d;
    endfunction

    assign pos_data = make_data(particle_id);

    pos_cache_read_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .particle_count (particle_count),
        .particle_id    (particle_id),
        .pos_data       (pos_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pos_data   (out_pos_data),
        .out_id         (out_id),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
        .stall_cycles   (stall_cycles)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input int n);
        exp_t e;
        @(posedge clk); #1;
        start          = 1'b1;
        particle_count = (AW+1)'(n);
        for (int i = 0; i < n; i++) begin
            e.id   = AW'(i);
            e.last = (i == n - 1);
            e.data = make_data(AW'(i));
            exp_q.push_back(e);
        end
        stall_base = stall_seen;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit got;
        got = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s: done=0 after %0d cycles, want done=1", name, max_cyc);
        end
    endtask

    task automatic chk_stall(input string name);
`ifdef POS_READ_PERF_EN
        chk(name, 64'(stall_cycles), 64'(stall_seen - stall_base));
`else
        chk(name, 64'(stall_cycles), 64'd0);
`endif
    endtask

    // Monitor: score accepted beats, check stalled beats stay put
    initial begin
        exp_t          e;
        bit            prev_stall = 1'b0;
        logic [AW-1:0] prev_id    = '0;
        logic          prev_last  = 1'b0;
        logic [W-1:0]  prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_id", 64'(out_id), 64'(prev_id));
                    chk("hold_last", 64'(out_last), 64'(prev_last));
                    chk("hold_data", 64'(out_pos_data == prev_data), 64'd1);
                end
                if (out_valid && !out_ready) stall_seen++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got id %0d, want no beat", out_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_id", 64'(out_id), 64'(e.id));
                        chk("beat_last", 64'(out_last), 64'(e.last));
                        n_vec++;
                        if (out_pos_data !== e.data) begin
                            n_err++;
                            $display("FAIL beat_data id %0d: got low %0h, want low %0h",
                                     e.id, out_pos_data[63:0], e.data[63:0]);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_id    = out_id;
                prev_last  = out_last;
                prev_data  = out_pos_data;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        rst            = 1'b1;
        start          = 1'b0;
        out_ready      = 1'b0;
        particle_count = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pid", 64'(particle_id), 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_data", 64'(out_pos_data == '0), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // count=5, full throughput: beats in cycles 2..6, done in cycle 7
        out_ready = 1'b1;
        do_start(5);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("a_valid_c%0d", k), 64'(out_valid), 64'(k >= 2 && k <= 6));
            chk($sformatf("a_last_c%0d", k), 64'(out_valid & out_last), 64'(k == 6));
            chk($sformatf("a_done_c%0d", k), 64'(done), 64'(k == 7));
            chk($sformatf("a_busy_c%0d", k), 64'(busy), 64'(k <= 7));
        end
        chk("a_queue_empty", 64'(exp_q.size()), 64'd0);

        // count=0: done the cycle after start, busy for one cycle only
        do_start(0);
        @(negedge clk);
        chk("b_done", 64'(done), 64'd1);
        chk("b_busy", 64'(busy), 64'd1);
        chk("b_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("b_done_end", 64'(done), 64'd0);
        chk("b_busy_end", 64'(busy), 64'd0);

        // count=10, out_ready toggling every cycle
        do_start(10);
        got = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            out_ready = ~out_ready;
        end
        chk("c_done_seen", 64'(got), 64'd1);
        chk("c_queue_empty", 64'(exp_q.size()), 64'd0);
        chk_stall("c_stall_cycles");
        out_ready = 1'b1;

        // count=8, consumer stalled 20 cycles: exactly DEPTH reads issued
        out_ready = 1'b0;
        do_start(8);
        repeat (20) @(negedge clk);
        chk("d_pid_stalled", 64'(particle_id), 64'(DEPTH - 1));
        chk("d_valid_stalled", 64'(out_valid), 64'd1);
        chk("d_head_id", 64'(out_id), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("d_done", 40);
        chk("d_queue_empty", 64'(exp_q.size()), 64'd0);
        chk_stall("d_stall_cycles");

        // count=20, reset right after id 3 is accepted
        do_start(20);
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_id == AW'(3)) begin
                got = 1'b1;
                break;
            end
        end
        chk("e_id3_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("e_rst_valid", 64'(out_valid), 64'd0);
        chk("e_rst_pid", 64'(particle_id), 64'd0);
        chk("e_rst_id", 64'(out_id), 64'd0);
        chk("e_rst_last", 64'(out_last), 64'd0);
        chk("e_rst_data", 64'(out_pos_data == '0), 64'd1);
        chk("e_rst_busy", 64'(busy), 64'd0);
        chk("e_rst_done", 64'(done), 64'd0);
        chk("e_rst_stall", 64'(stall_cycles), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("e_quiet_valid", 64'(out_valid), 64'd0);
        chk("e_quiet_busy", 64'(busy), 64'd0);
        do_start(2);
        wait_done("e_done", 20);
        chk("e_queue_empty", 64'(exp_q.size()), 64'd0);

        // count=128: full id range; a start while busy is ignored
        do_start(128);
        repeat (5) @(posedge clk);
        #1;
        start          = 1'b1;
        particle_count = (AW+1)'(5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("f_done", 300);
        chk("f_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (5) @(negedge clk);
        chk("f_idle_valid", 64'(out_valid), 64'd0);
        chk("f_idle_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
